// File: rtl/cordic_rot_replay_engine_if.sv
// Handshake/data bundle between the vectoring chain, the rotation replay engine and the caller.
// Signal names follow the block's documented port list.
interface cordic_rot_replay_engine_if #(
  parameter int unsigned CORDIC_WIDTH = 22
);
  logic                           micro_rot_i;
  logic                           micro_rot_valid_i;
  logic                           microRot_in_start;
  logic                           inverse;
  logic                           enable;
  logic signed [CORDIC_WIDTH-1:0] x_in;
  logic signed [CORDIC_WIDTH-1:0] y_in;
  logic signed [CORDIC_WIDTH-1:0] x_out;
  logic signed [CORDIC_WIDTH-1:0] y_out;
  logic                           dirs_ready;
  logic                           busy;
  logic                           done;
  logic                           start_err;

  modport master (
    output micro_rot_i, micro_rot_valid_i, microRot_in_start, inverse, enable, x_in, y_in,
    input  x_out, y_out, dirs_ready, busy, done, start_err
  );

  modport slave (
    input  micro_rot_i, micro_rot_valid_i, microRot_in_start, inverse, enable, x_in, y_in,
    output x_out, y_out, dirs_ready, busy, done, start_err
  );
endinterface

// File: rtl/cordic_rot_replay_engine.sv
// Captures CORDIC vectoring direction bits and replays them, one micro-rotation per cycle,
// on a new vector (forward or inverse). No gain compensation is applied here.
module cordic_rot_replay_engine #(
  parameter int unsigned CORDIC_WIDTH = 22,
  parameter int unsigned N_ITER       = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic                        clk,
  input  logic                        nreset,
  cordic_rot_replay_engine_if.slave   bus
);

  localparam int unsigned IdxW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;

  state_e state_q, state_d;

  logic [N_ITER-1:0]              cap_buf_q, cap_buf_d;
  logic [CNT_W-1:0]               cap_cnt_q, cap_cnt_d;
  logic                           dirs_ready_q, dirs_ready_d;
  logic [N_ITER-1:0]              work_q, work_d;
  logic                           inv_q, inv_d;
  logic [CNT_W-1:0]               iter_q, iter_d;
  logic signed [CORDIC_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic signed [CORDIC_WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           start_err_q, start_err_d;

  logic                           dir;
  logic signed [CORDIC_WIDTH-1:0] x_sh, y_sh;

  // State register and all datapath/output registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= StIdle;
      cap_buf_q    <= '0;
      cap_cnt_q    <= '0;
      dirs_ready_q <= 1'b0;
      work_q       <= '0;
      inv_q        <= 1'b0;
      iter_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_buf_q    <= cap_buf_d;
      cap_cnt_q    <= cap_cnt_d;
      dirs_ready_q <= dirs_ready_d;
      work_q       <= work_d;
      inv_q        <= inv_d;
      iter_q       <= iter_d;
      x_q          <= x_d;
      y_q          <= y_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_err_q  <= start_err_d;
    end
  end

  // Capture runs regardless of FSM state; the rotation works from its own copy.
  always_comb begin
    cap_buf_d    = cap_buf_q;
    cap_cnt_d    = cap_cnt_q;
    dirs_ready_d = dirs_ready_q;
    if (bus.micro_rot_valid_i) begin
      if (bus.microRot_in_start) begin
        cap_buf_d    = '0;
        cap_buf_d[0] = bus.micro_rot_i;
        cap_cnt_d    = CNT_W'(1);
        dirs_ready_d = (N_ITER == 1);
      end else if (cap_cnt_q != '0 && cap_cnt_q < CNT_W'(N_ITER)) begin
        cap_buf_d[cap_cnt_q[IdxW-1:0]] = bus.micro_rot_i;
        cap_cnt_d    = cap_cnt_q + CNT_W'(1);
        dirs_ready_d = (cap_cnt_q == CNT_W'(N_ITER - 1));
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.enable && dirs_ready_q) state_d = StRotate;
      StRotate: if (iter_q == CNT_W'(N_ITER - 1)) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Shifting by iter_q == 0 reproduces the unscaled 45 degree first stage.
  assign dir  = work_q[iter_q[IdxW-1:0]] ^ inv_q;
  assign x_sh = x_q >>> iter_q;
  assign y_sh = y_q >>> iter_q;

  // Datapath and output next-state logic.
  always_comb begin
    work_d      = work_q;
    inv_d       = inv_q;
    iter_d      = iter_q;
    x_d         = x_q;
    y_d         = y_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          if (dirs_ready_q) begin
            x_d    = bus.x_in;
            y_d    = bus.y_in;
            work_d = cap_buf_q;
            inv_d  = bus.inverse;
            iter_d = '0;
            busy_d = 1'b1;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      StRotate: begin
        if (dir) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
        end
        iter_d      = iter_q + CNT_W'(1);
        start_err_d = bus.enable;
      end
      StDone: begin
        x_out_d     = x_q;
        y_out_d     = y_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        start_err_d = bus.enable;
      end
      default: ;
    endcase
  end

  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.dirs_ready = dirs_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.start_err  = start_err_q;

endmodule

// File: tb/tb_cordic_rot_replay_engine.sv
// Bench for cordic_rot_replay_engine: a 2-stage instance for directed vectors and a default
// 16-stage instance for randomized replay against a plain-arithmetic CORDIC model.
module tb_cordic_rot_replay_engine;

  localparam int W  = 22;
  localparam int NB = 16;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  cordic_rot_replay_engine_if #(.CORDIC_WIDTH(W)) bs ();
  cordic_rot_replay_engine_if #(.CORDIC_WIDTH(W)) bb ();

  cordic_rot_replay_engine #(.CORDIC_WIDTH(W), .N_ITER(NS), .CNT_W(5)) u_small (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bs)
  );

  cordic_rot_replay_engine #(.CORDIC_WIDTH(W), .N_ITER(NB), .CNT_W(5)) u_big (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bb)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  function automatic longint wrapw(input longint v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return longint'($signed(t));
  endfunction

  // floor(v / 2^s) via integer division with rounding toward minus infinity
  function automatic longint floor_div_pow2(input longint v, input int s);
    longint p, q;
    p = longint'(1) << s;
    q = v / p;
    if (v < 0 && (q * p) != v) q = q - 1;
    return q;
  endfunction

  task automatic model_rot(input longint x0, input longint y0, input logic [31:0] bits,
                           input bit inv, input int n, output longint xr, output longint yr);
    longint x, y, nx, ny;
    x = x0;
    y = y0;
    for (int k = 0; k < n; k++) begin
      if (bits[k] ^ inv) begin  // counter-clockwise
        nx = x - floor_div_pow2(y, k);
        ny = y + floor_div_pow2(x, k);
      end else begin
        nx = x + floor_div_pow2(y, k);
        ny = y - floor_div_pow2(x, k);
      end
      x = wrapw(nx);
      y = wrapw(ny);
    end
    xr = x;
    yr = y;
  endtask

  // Vectoring: choose each direction to drive y toward zero.
  task automatic model_vec(input longint x0, input longint y0, input int n,
                           output logic [31:0] bits);
    longint x, y, nx, ny;
    x = x0;
    y = y0;
    bits = '0;
    for (int k = 0; k < n; k++) begin
      bits[k] = (y < 0);
      if (bits[k]) begin
        nx = x - floor_div_pow2(y, k);
        ny = y + floor_div_pow2(x, k);
      end else begin
        nx = x + floor_div_pow2(y, k);
        ny = y - floor_div_pow2(x, k);
      end
      x = wrapw(nx);
      y = wrapw(ny);
    end
  endtask

  function automatic longint rnd_coord();
    return longint'($urandom_range(1200000, 0)) - 600000;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cap(input bit big, input bit v, input bit s, input bit b);
    if (big) begin
      bb.micro_rot_valid_i = v; bb.microRot_in_start = s; bb.micro_rot_i = b;
    end else begin
      bs.micro_rot_valid_i = v; bs.microRot_in_start = s; bs.micro_rot_i = b;
    end
  endtask

  task automatic set_en(input bit big, input bit en, input bit inv, input longint x,
                        input longint y);
    logic [W-1:0] xt, yt;
    xt = x[W-1:0];
    yt = y[W-1:0];
    if (big) begin
      bb.enable = en; bb.inverse = inv; bb.x_in = xt; bb.y_in = yt;
    end else begin
      bs.enable = en; bs.inverse = inv; bs.x_in = xt; bs.y_in = yt;
    end
  endtask

  function automatic logic get_done(input bit big);
    return big ? bb.done : bs.done;
  endfunction

  task automatic cap(input bit big, input logic [31:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      set_cap(big, 1'b1, k == 0, bits[k]);
      tick();
    end
    set_cap(big, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run(input bit big, input bit inv, input longint x, input longint y,
                     output int lat);
    set_en(big, 1'b1, inv, x, y);
    tick();
    set_en(big, 1'b0, 1'b0, 0, 0);
    lat = 0;
    while (!get_done(big) && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_cap(1'b0, 1'b0, 1'b0, 1'b0);
    set_cap(1'b1, 1'b0, 1'b0, 1'b0);
    set_en(1'b0, 1'b0, 1'b0, 0, 0);
    set_en(1'b1, 1'b0, 1'b0, 0, 0);
    nreset = 1'b0;
    tick();
    tick();
    checks += 6;
    if (bb.x_out !== '0) begin errors++; $display("FAIL reset_x_out: got %0d expected 0", bb.x_out); end
    if (bb.y_out !== '0) begin errors++; $display("FAIL reset_y_out: got %0d expected 0", bb.y_out); end
    if (bb.dirs_ready !== 1'b0) begin errors++; $display("FAIL reset_dirs_ready: got %b expected 0", bb.dirs_ready); end
    if (bb.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bb.busy); end
    if (bb.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bb.done); end
    if (bb.start_err !== 1'b0) begin errors++; $display("FAIL reset_start_err: got %b expected 0", bb.start_err); end
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_small_vectors();
    logic [31:0] tbits[3];
    bit          tinv[3];
    longint      tx[3], ty[3], ex[3], ey[3];
    int          lat;
    tbits = '{32'b00, 32'b00, 32'b10};
    tinv  = '{1'b0, 1'b1, 1'b0};
    tx    = '{1000, 1000, -800};
    ty    = '{0, 0, 400};
    ex    = '{500, 500, -1000};
    ey    = '{-1500, 1500, 1000};
    for (int t = 0; t < 3; t++) begin
      cap(1'b0, tbits[t], NS);
      checks++;
      if (bs.dirs_ready !== 1'b1) begin errors++; $display("FAIL small_dirs_ready[%0d]: got %b expected 1", t, bs.dirs_ready); end
      run(1'b0, tinv[t], tx[t], ty[t], lat);
      checks += 3;
      if (lat != NS + 1) begin errors++; $display("FAIL small_latency[%0d]: got %0d expected %0d", t, lat, NS + 1); end
      if (longint'($signed(bs.x_out)) !== ex[t]) begin errors++; $display("FAIL small_x[%0d]: got %0d expected %0d", t, $signed(bs.x_out), ex[t]); end
      if (longint'($signed(bs.y_out)) !== ey[t]) begin errors++; $display("FAIL small_y[%0d]: got %0d expected %0d", t, $signed(bs.y_out), ey[t]); end
      tick();
      checks++;
      if (bs.done !== 1'b0) begin errors++; $display("FAIL small_done_pulse[%0d]: got %b expected 0", t, bs.done); end
    end
  endtask

  task automatic test_start_err();
    int lat;
    set_cap(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_cap(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bs.dirs_ready !== 1'b0) begin errors++; $display("FAIL partial_dirs_ready: got %b expected 0", bs.dirs_ready); end
    set_en(1'b0, 1'b1, 1'b0, 7, 7);
    tick();
    set_en(1'b0, 1'b0, 1'b0, 0, 0);
    checks += 2;
    if (bs.start_err !== 1'b1) begin errors++; $display("FAIL err_not_ready: got %b expected 1", bs.start_err); end
    if (bs.busy !== 1'b0) begin errors++; $display("FAIL busy_not_ready: got %b expected 0", bs.busy); end
    tick();
    checks++;
    if (bs.start_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", bs.start_err); end
    // complete {0,1}, then a surplus bit that must be ignored
    set_cap(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    set_cap(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_cap(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bs.dirs_ready !== 1'b1) begin errors++; $display("FAIL full_dirs_ready: got %b expected 1", bs.dirs_ready); end
    set_en(1'b0, 1'b1, 1'b0, -800, 400);
    tick();
    set_en(1'b0, 1'b1, 1'b1, 5, 5);
    tick();
    set_en(1'b0, 1'b0, 1'b0, 0, 0);
    lat = 1;
    checks += 2;
    if (bs.start_err !== 1'b1) begin errors++; $display("FAIL err_busy: got %b expected 1", bs.start_err); end
    if (bs.busy !== 1'b1) begin errors++; $display("FAIL busy_during_rot: got %b expected 1", bs.busy); end
    while (!bs.done && lat < 40) begin
      tick();
      lat++;
    end
    checks += 3;
    if (lat != NS + 1) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", lat, NS + 1); end
    if (longint'($signed(bs.x_out)) !== -1000) begin errors++; $display("FAIL busy_x: got %0d expected -1000", $signed(bs.x_out)); end
    if (longint'($signed(bs.y_out)) !== 1000) begin errors++; $display("FAIL busy_y: got %0d expected 1000", $signed(bs.y_out)); end
    tick();
  endtask

  task automatic test_replay(output logic [31:0] cur);
    logic [31:0] nxt;
    longint      x, y, ex, ey;
    bit          inv;
    int          lat, k;
    model_vec(rnd_coord(), rnd_coord(), NB, cur);
    cap(1'b1, cur, NB);
    for (int it = 0; it < 8; it++) begin
      x   = rnd_coord();
      y   = rnd_coord();
      inv = (it % 3 != 2);
      model_rot(x, y, cur, inv, NB, ex, ey);
      model_vec(rnd_coord(), rnd_coord(), NB, nxt);
      // new set starts on the same edge as enable and refills during the rotation
      set_en(1'b1, 1'b1, inv, x, y);
      set_cap(1'b1, 1'b1, 1'b1, nxt[0]);
      tick();
      set_en(1'b1, 1'b0, 1'b0, 0, 0);
      lat = 0;
      k = 1;
      while (!bb.done && lat < 40) begin
        if (k < NB) begin
          set_cap(1'b1, 1'b1, 1'b0, nxt[k]);
          k++;
        end else begin
          set_cap(1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        lat++;
      end
      set_cap(1'b1, 1'b0, 1'b0, 1'b0);
      checks += 4;
      if (lat != NB + 1) begin errors++; $display("FAIL replay_latency[%0d]: got %0d expected %0d", it, lat, NB + 1); end
      if (longint'($signed(bb.x_out)) !== ex) begin errors++; $display("FAIL replay_x[%0d]: got %0d expected %0d", it, $signed(bb.x_out), ex); end
      if (longint'($signed(bb.y_out)) !== ey) begin errors++; $display("FAIL replay_y[%0d]: got %0d expected %0d", it, $signed(bb.y_out), ey); end
      if (bb.dirs_ready !== 1'b1) begin errors++; $display("FAIL replay_refill[%0d]: got %b expected 1", it, bb.dirs_ready); end
      cur = nxt;
      tick();
    end
  endtask

  task automatic test_reset_mid(input logic [31:0] cur);
    logic [31:0] fresh;
    longint      ex, ey;
    int          dones, lat;
    set_en(1'b1, 1'b1, 1'b1, 12345, -54321);
    tick();
    set_en(1'b1, 1'b0, 1'b0, 0, 0);
    repeat (7) tick();
    nreset = 1'b0;
    #1;
    checks += 6;
    if (bb.x_out !== '0) begin errors++; $display("FAIL abort_x_out: got %0d expected 0", bb.x_out); end
    if (bb.y_out !== '0) begin errors++; $display("FAIL abort_y_out: got %0d expected 0", bb.y_out); end
    if (bb.dirs_ready !== 1'b0) begin errors++; $display("FAIL abort_dirs_ready: got %b expected 0", bb.dirs_ready); end
    if (bb.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bb.busy); end
    if (bb.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bb.done); end
    if (bb.start_err !== 1'b0) begin errors++; $display("FAIL abort_start_err: got %b expected 0", bb.start_err); end
    tick();
    nreset = 1'b1;
    dones = 0;
    for (int c = 0; c < NB + 4; c++) begin
      tick();
      if (bb.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    // non-start bits after reset land on cap_cnt==0 and are dropped
    for (int k = 0; k < NB; k++) begin
      set_cap(1'b1, 1'b1, 1'b0, cur[k]);
      tick();
    end
    set_cap(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bb.dirs_ready !== 1'b0) begin errors++; $display("FAIL nostart_dirs_ready: got %b expected 0", bb.dirs_ready); end
    model_vec(rnd_coord(), rnd_coord(), NB, fresh);
    cap(1'b1, fresh, NB - 1);
    checks++;
    if (bb.dirs_ready !== 1'b0) begin errors++; $display("FAIL fifteen_dirs_ready: got %b expected 0", bb.dirs_ready); end
    cap(1'b1, fresh, NB);
    checks++;
    if (bb.dirs_ready !== 1'b1) begin errors++; $display("FAIL fresh_dirs_ready: got %b expected 1", bb.dirs_ready); end
    model_rot(-300000, 250000, fresh, 1'b1, NB, ex, ey);
    run(1'b1, 1'b1, -300000, 250000, lat);
    checks += 3;
    if (lat != NB + 1) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, NB + 1); end
    if (longint'($signed(bb.x_out)) !== ex) begin errors++; $display("FAIL post_reset_x: got %0d expected %0d", $signed(bb.x_out), ex); end
    if (longint'($signed(bb.y_out)) !== ey) begin errors++; $display("FAIL post_reset_y: got %0d expected %0d", $signed(bb.y_out), ey); end
    tick();
  endtask

  initial begin
    logic [31:0] cur;
    test_reset();
    test_small_vectors();
    test_start_err();
    test_replay(cur);
    test_reset_mid(cur);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
